fwd_bypass_unit: RTL

- Consumer end of the ID/EX forwarding value: captures the EX-stage forward value (link PC+1, slt/sgt flag, ALU result) into EX/MEM and MEM/WB tracking registers.
- Supplies bypassed rs/rt operands to the ID stage.
- Raises a load-use hazard stall when a forward value cannot be delivered in time.
- Sits between the ID/EX register and the register file read path of the 8-bit pipelined core.

---
 rtl/fwd_pkg.sv | 21 ++
 rtl/fwd_stage_reg.sv | 29 ++
 rtl/fwd_bypass_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types and defaults for the forwarding/bypass unit of the 8-bit pipelined core.
package fwd_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;

  localparam logic [REG_ADDR_W-1:0] FWD_ZERO_REG = '0;

  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     value;
  } fwd_stage_t;

  function automatic logic stage_match(fwd_stage_t st, logic [REG_ADDR_W-1:0] src);
    return st.valid & st.wr_en & (st.rd == src) & (src != FWD_ZERO_REG);
  endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One forwarding tracking register: async reset, flush inserts a bubble, hold freezes.
module fwd_stage_reg
  import fwd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       hold,
  input  fwd_stage_t d,
  output fwd_stage_t q
);

  fwd_stage_t bubble;

  always_comb begin
    bubble       = d;
    bubble.valid = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (flush)
      q <= bubble;
    else if (!hold)
      q <= d;
  end

endmodule

// File: rtl/fwd_bypass_unit.sv
// EX/MEM and MEM/WB forward tracking, ID operand bypass and load-use stall detection.
// Optional statistics counters are enabled by defining FWD_STATS_EN.
module fwd_bypass_unit #(
  parameter int DATA_W     = fwd_pkg::DATA_W,
  parameter int REG_ADDR_W = fwd_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_stall,
  input  logic                  pipe_flush,
  input  logic                  ex_valid,
  input  logic                  ex_wr_en,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0]     ex_fwd_value,
  input  logic [DATA_W-1:0]     mem_load_data,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [DATA_W-1:0]     rf_rs_data,
  input  logic [DATA_W-1:0]     rf_rt_data,
  output logic [DATA_W-1:0]     id_rs_val,
  output logic [DATA_W-1:0]     id_rt_val,
  output logic                  hazard_stall,
  output logic                  wb_wr_en,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_data
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]           fwd_hit_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  import fwd_pkg::*;

  fwd_stage_t ex_in, ex_mem, mem_in, mem_wb;
  logic       rs_em, rs_mw, rt_em, rt_mw;

  always_comb begin
    ex_in = '{valid: ex_valid, wr_en: ex_wr_en, is_load: ex_is_load,
              rd: ex_rd, value: ex_fwd_value};
    // Load data is resolved on entry to MEM/WB, so MEM/WB never carries a pending load.
    mem_in = ex_mem;
    if (ex_mem.is_load) begin
      mem_in.value   = mem_load_data;
      mem_in.is_load = 1'b0;
    end
  end

  fwd_stage_reg u_ex_mem (
    .clk   (clk),
    .rst   (rst),
    .flush (pipe_flush),
    .hold  (pipe_stall),
    .d     (ex_in),
    .q     (ex_mem)
  );

  // A flush still lets MEM/WB advance from the old EX/MEM contents.
  fwd_stage_reg u_mem_wb (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .hold  (pipe_stall & ~pipe_flush),
    .d     (mem_in),
    .q     (mem_wb)
  );

  always_comb begin
    rs_em = stage_match(ex_mem, id_rs);
    rs_mw = stage_match(mem_wb, id_rs);
    rt_em = stage_match(ex_mem, id_rt);
    rt_mw = stage_match(mem_wb, id_rt);

    id_rs_val = rf_rs_data;
    if (id_rs == FWD_ZERO_REG) id_rs_val = '0;
    else if (rs_em)            id_rs_val = mem_in.value;
    else if (rs_mw)            id_rs_val = mem_wb.value;

    id_rt_val = rf_rt_data;
    if (id_rt == FWD_ZERO_REG) id_rt_val = '0;
    else if (rt_em)            id_rt_val = mem_in.value;
    else if (rt_mw)            id_rt_val = mem_wb.value;

    hazard_stall = ex_valid & ex_wr_en & ex_is_load & (ex_rd != FWD_ZERO_REG) &
                   ((ex_rd == id_rs) | (ex_rd == id_rt));
  end

  always_comb begin
    wb_wr_en = mem_wb.valid & mem_wb.wr_en;
    wb_rd    = mem_wb.rd;
    wb_data  = mem_wb.value;
  end

`ifdef FWD_STATS_EN
  logic fwd_hit;

  always_comb fwd_hit = ~pipe_stall & (rs_em | rs_mw | rt_em | rt_mw);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_hit_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (fwd_hit && fwd_hit_cnt != '1)    fwd_hit_cnt <= fwd_hit_cnt + 16'd1;
      if (hazard_stall && stall_cnt != '1) stall_cnt   <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
